// File: rtl/shot_slot_scheduler_if.sv
// Bundle between player input, the shot mover pool and the shot slot scheduler.
// master drives fire/frame/slot status; slave (the scheduler) drives launch and status outputs.
interface shot_slot_scheduler_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                 startOfFrame;
    logic                 pause;
    logic                 fireRequest;
    logic [2:0]           shotDirection;
    logic [NUM_SLOTS-1:0] slotFree;
    logic [NUM_SLOTS-1:0] triggerShot;
    logic [2:0]           shotDirOut;
    logic                 shotDropped;
    logic                 coolingDown;
    logic [7:0]           shotsFired;
    logic [3:0]           ammo;

    modport master (
        output startOfFrame, pause, fireRequest, shotDirection, slotFree,
        input  triggerShot, shotDirOut, shotDropped, coolingDown, shotsFired, ammo
    );

    modport slave (
        input  startOfFrame, pause, fireRequest, shotDirection, slotFree,
        output triggerShot, shotDirOut, shotDropped, coolingDown, shotsFired, ammo
    );
endinterface

// File: rtl/shot_slot_scheduler.sv
// Round-robin shot slot scheduler with per-frame cooldown between grants.
// Optional ammo/reload feature is built when SHOT_AMMO_EN is defined.
module shot_slot_scheduler #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned COOLDOWN_FRAMES = 6,
    parameter int unsigned AMMO_MAX        = 10
`ifdef SHOT_AMMO_EN
    ,
    parameter int unsigned RELOAD_FRAMES   = 30
`endif
) (
    input logic                  clk,
    input logic                  reset,
    shot_slot_scheduler_if.slave bus
);
    localparam int unsigned SlotW = $clog2(NUM_SLOTS);
    localparam logic [SlotW:0] NumSlotsW = (SlotW + 1)'(NUM_SLOTS);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GRANT    = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             fire_q;
    logic             fire_edge;
    logic             frame_tick;
    logic [SlotW-1:0] rr_ptr_q;
    logic [SlotW-1:0] slot_q;
    logic [SlotW-1:0] pick;
    logic             any_free;
    logic [2:0]       dir_q;
    logic [7:0]       cd_cnt_q;
    logic [7:0]       shots_q;
    logic             dropped_q, dropped_d;
    logic [3:0]       ammo_q;
    logic             ammo_ok;

    assign fire_edge  = bus.fireRequest & ~fire_q;
    assign frame_tick = bus.startOfFrame & ~bus.pause;

    // Scan from the highest offset down so the slot nearest rr_ptr_q wins.
    always_comb begin
        logic [SlotW:0] idx;
        idx      = '0;
        pick     = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (SlotW + 1)'(i);
            if (idx >= NumSlotsW) idx = idx - NumSlotsW;
            if (bus.slotFree[idx[SlotW-1:0]]) begin
                pick     = idx[SlotW-1:0];
                any_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dropped_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_edge && !bus.pause) begin
                    if (any_free && ammo_ok) state_d = GRANT;
                    else                     dropped_d = 1'b1;
                end
            end
            GRANT: begin
                state_d = COOLDOWN;
                if (fire_edge && !bus.pause) dropped_d = 1'b1;
            end
            COOLDOWN: begin
                if (frame_tick && cd_cnt_q == 8'd1) state_d = IDLE;
                if (fire_edge && !bus.pause) dropped_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fire_q    <= 1'b0;
            rr_ptr_q  <= '0;
            slot_q    <= '0;
            dir_q     <= 3'd0;
            cd_cnt_q  <= 8'd0;
            shots_q   <= 8'd0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fire_q    <= bus.fireRequest;
            dropped_q <= dropped_d;
            if (state_q == IDLE && state_d == GRANT) begin
                slot_q <= pick;
                dir_q  <= bus.shotDirection;
            end
            if (state_q == GRANT) begin
                rr_ptr_q <= (slot_q == SlotW'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
                cd_cnt_q <= 8'(COOLDOWN_FRAMES);
                if (shots_q != 8'hFF) shots_q <= shots_q + 8'd1;
            end else if (state_q == COOLDOWN && frame_tick) begin
                cd_cnt_q <= cd_cnt_q - 8'd1;
            end
        end
    end

`ifdef SHOT_AMMO_EN
    localparam int unsigned RelW = $clog2(RELOAD_FRAMES + 1);

    logic [RelW-1:0] reload_q;
    logic            reload_wrap;
    logic            refill;
    logic            spend;

    assign reload_wrap = (reload_q == RelW'(RELOAD_FRAMES - 1));
    assign refill      = frame_tick && reload_wrap && (ammo_q < 4'(AMMO_MAX));
    assign spend       = (state_q == GRANT);
    assign ammo_ok     = (ammo_q != 4'd0);

    // Reload timer free-runs on unpaused frames; a simultaneous spend and refill cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            ammo_q   <= 4'(AMMO_MAX);
            reload_q <= '0;
        end else begin
            if (frame_tick) reload_q <= reload_wrap ? '0 : reload_q + 1'b1;
            if (spend && !refill)      ammo_q <= ammo_q - 4'd1;
            else if (refill && !spend) ammo_q <= ammo_q + 4'd1;
        end
    end
`else
    assign ammo_q  = 4'(AMMO_MAX);
    assign ammo_ok = 1'b1;
`endif

    always_comb begin
        bus.triggerShot = '0;
        if (state_q == GRANT) bus.triggerShot[slot_q] = 1'b1;
    end

    assign bus.shotDirOut  = (state_q == GRANT) ? dir_q : 3'd0;
    assign bus.shotDropped = dropped_q;
    assign bus.coolingDown = (state_q == COOLDOWN);
    assign bus.shotsFired  = shots_q;
    assign bus.ammo        = ammo_q;
endmodule

// File: tb/tb_shot_slot_scheduler.sv
// Scoreboard bench for shot_slot_scheduler: directed scenarios then random stimulus.
module tb_shot_slot_scheduler;
    localparam int unsigned NS = 4;
`ifdef SHOT_AMMO_EN
    localparam int unsigned CD = 1;
    localparam int unsigned AM = 2;
    localparam bit AMMO_EN = 1'b1;
`else
    localparam int unsigned CD = 6;
    localparam int unsigned AM = 10;
    localparam bit AMMO_EN = 1'b0;
`endif
    localparam int unsigned RF = 30;

    typedef struct {
        int            cyc;
        logic [NS-1:0] trig;
        logic [2:0]    dir;
        logic          drop;
    } evt_t;

    typedef struct {
        int         cyc;
        logic       cool;
        logic [7:0] shots;
        logic [3:0] ammo;
    } st_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   first_cyc = 0;
    bit   chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    evt_t evq[$];
    st_t  stq[$];
    evt_t me;
    st_t  ms;

    // Reference model: launch pending, frames of cooldown left, counters.
    bit m_fire_prev, m_launch;
    int m_slot, m_rr, m_left, m_shots, m_ammo, m_ticks;
    logic [2:0] m_dir;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shot_slot_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    shot_slot_scheduler #(
        .NUM_SLOTS      (NS),
        .COOLDOWN_FRAMES(CD),
        .AMMO_MAX       (AM)
`ifdef SHOT_AMMO_EN
        ,
        .RELOAD_FRAMES  (RF)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic step(input bit rst, input bit fr, input bit pz, input bit sof,
                        input logic [2:0] dir, input logic [NS-1:0] free);
        evt_t e;
        st_t  s;
        bit edge_s, tick, dec, inc, drop;
        logic [NS-1:0] trig;
        int pick;
        reset             = rst;
        bus.fireRequest   = fr;
        bus.pause         = pz;
        bus.startOfFrame  = sof;
        bus.shotDirection = dir;
        bus.slotFree      = free;
        trig = '0;
        drop = 1'b0;
        if (rst) begin
            m_fire_prev = 1'b0; m_launch = 1'b0; m_rr = 0; m_left = 0;
            m_shots = 0; m_ammo = AM; m_ticks = 0; m_slot = 0; m_dir = 3'd0;
        end else begin
            edge_s = fr && !m_fire_prev;
            tick   = sof && !pz;
            dec    = 1'b0;
            inc    = 1'b0;
            if (m_launch) begin
                m_launch = 1'b0;
                dec = AMMO_EN;
                if (m_shots < 255) m_shots++;
                m_rr   = (m_slot + 1) % NS;
                m_left = CD;
                if (edge_s && !pz) drop = 1'b1;
            end else if (m_left > 0) begin
                if (edge_s && !pz) drop = 1'b1;
                if (tick) m_left--;
            end else if (edge_s && !pz) begin
                pick = -1;
                for (int i = 0; i < NS; i++)
                    if (pick < 0 && free[(m_rr + i) % NS]) pick = (m_rr + i) % NS;
                if (pick >= 0 && (!AMMO_EN || m_ammo > 0)) begin
                    m_launch = 1'b1;
                    m_slot   = pick;
                    m_dir    = dir;
                    trig[pick] = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            if (AMMO_EN && tick) begin
                m_ticks++;
                if (m_ticks % RF == 0 && m_ammo < AM) inc = 1'b1;
            end
            if (dec && !inc)      m_ammo--;
            else if (inc && !dec) m_ammo++;
            m_fire_prev = fr;
        end
        e.cyc  = cyc + 1;
        e.trig = trig;
        e.dir  = (trig != '0) ? m_dir : 3'd0;
        e.drop = drop;
        if (trig != '0 || drop) evq.push_back(e);
        s.cyc   = cyc + 1;
        s.cool  = (m_left > 0);
        s.shots = 8'(m_shots);
        s.ammo  = 4'(m_ammo);
        stq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [NS-1:0] free);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, free);
    endtask

    task automatic frames(input int n, input bit pz, input logic [NS-1:0] free);
        repeat (n) begin
            step(1'b0, 1'b0, pz, 1'b1, 3'd0, free);
            idle(3, free);
        end
    endtask

    task automatic press(input logic [2:0] dir, input logic [NS-1:0] free);
        step(1'b0, 1'b1, 1'b0, 1'b0, dir, free);
        step(1'b0, 1'b0, 1'b0, 1'b0, dir, free);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc >= first_cyc) begin
            while (stq.size() > 0 && stq[0].cyc < cyc) begin
                ms = stq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL status_lost cyc=%0d", ms.cyc);
            end
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                ms = stq.pop_front();
                n_tests++;
                if (bus.coolingDown !== ms.cool || bus.shotsFired !== ms.shots ||
                    bus.ammo !== ms.ammo) begin
                    n_fail++;
                    $display("FAIL status cyc=%0d got cool=%b shots=%0d ammo=%0d want cool=%b shots=%0d ammo=%0d",
                             cyc, bus.coolingDown, bus.shotsFired, bus.ammo,
                             ms.cool, ms.shots, ms.ammo);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                me = evq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL event_lost cyc=%0d want trig=%b drop=%b", me.cyc, me.trig, me.drop);
            end
            if (bus.triggerShot !== '0 || bus.shotDropped !== 1'b0) begin
                n_tests++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    me = evq.pop_front();
                    if (bus.triggerShot !== me.trig || bus.shotDropped !== me.drop ||
                        bus.shotDirOut !== me.dir) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d got trig=%b dir=%b drop=%b want trig=%b dir=%b drop=%b",
                                 cyc, bus.triggerShot, bus.shotDirOut, bus.shotDropped,
                                 me.trig, me.dir, me.drop);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got trig=%b drop=%b want none",
                             cyc, bus.triggerShot, bus.shotDropped);
                end
            end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
                me = evq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missing_event cyc=%0d got none want trig=%b drop=%b",
                         cyc, me.trig, me.drop);
            end
        end
    end

    initial begin
        bit fr, pz, sof, rst;
        logic [NS-1:0] free;
        reset = 1'b1;
        bus.fireRequest = 1'b0; bus.pause = 1'b0; bus.startOfFrame = 1'b0;
        bus.shotDirection = 3'd0; bus.slotFree = '1;
        @(posedge clk);
        #1;
        first_cyc = cyc + 1;
        chk_en    = 1'b1;

        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
        press(3'b010, 4'hF);                  // first grant from slot 0
        idle(2, 4'b1110);
        frames(2, 1'b0, 4'b1110);
        press(3'b101, 4'b1110);               // early edge is dropped
        frames(CD, 1'b0, 4'b1110);
        press(3'b011, 4'b1110);               // round-robin to slot 1
        frames(CD + 1, 1'b0, 4'hF);
        press(3'b001, 4'hF);
        frames(CD + 1, 1'b0, 4'hF);
        press(3'b111, 4'b0001);               // wraps from rrPtr=3 to slot 0
        frames(CD + 1, 1'b0, 4'hF);
        press(3'b100, 4'h0);                  // no free slot
        press(3'b110, 4'hF);
        frames(10, 1'b1, 4'hF);               // paused cooldown holds
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'hF);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'hF);
        frames(CD, 1'b0, 4'hF);
        press(3'b010, 4'hF);
        frames(1, 1'b0, 4'hF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
        press(3'b011, 4'hF);                  // after reset starts at slot 0
        frames(CD + 1, 1'b0, 4'hF);
        repeat (3) begin
            press(3'b001, 4'hF);
            frames(CD + 1, 1'b0, 4'hF);
        end
        frames(RF, 1'b0, 4'hF);
        press(3'b101, 4'hF);

        fr = 1'b0;
        pz = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(2) == 0) fr = ~fr;
            if ($urandom_range(39) == 0) pz = ~pz;
            sof  = ($urandom_range(3) == 0);
            rst  = ($urandom_range(399) == 0);
            free = ($urandom_range(9) == 0) ? '0 : NS'($urandom | $urandom);
            step(rst, fr, pz, sof, 3'($urandom), free);
        end
        idle(3, 4'hF);
        repeat (2) @(negedge clk);
        while (evq.size() > 0) begin
            me = evq.pop_front();
            n_tests++; n_fail++;
            $display("FAIL leftover_event cyc=%0d want trig=%b drop=%b", me.cyc, me.trig, me.drop);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
